// File: rtl/gpio_stream_ctrl.sv
// gpio_stream_ctrl: launches a processor run and buffers its GPIO byte stream
// in a small first-word-fall-through FIFO. It throttles the processor when the
// FIFO nears full, and counts the bytes the sink accepts until a frame is done.
module gpio_stream_ctrl #(
  parameter int DEPTH       = 16,
  parameter int FRAME_BYTES = 152100,
  parameter int CNT_W       = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             GPIOEn,
  input  logic [7:0]       GPIO,
  output logic             cpu_run,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] byte_count,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BYTES);
  localparam logic [AW:0]      FULL_CNT   = (AW+1)'(DEPTH);
  // Two entries of slack cover writes already in flight when cpu_run drops.
  localparam logic [AW:0]      RUN_LIMIT  = (AW+1)'(DEPTH - 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      fifo_count;
  logic [CNT_W-1:0] in_count;
  logic [CNT_W-1:0] byte_count_r;
  logic             overflow_r;

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push_req;
  logic push;
  logic drop;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FULL_CNT);

  // The head byte is presented directly; an empty FIFO shows zero.
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? 8'h00 : mem[rd_ptr];

  // A pop is only possible when a byte is presented, so pushing into an
  // empty FIFO never pairs with a pop.
  assign pop      = out_valid && out_ready;
  assign push_req = (state == RUN) && GPIOEn;
  assign push     = push_req && (!fifo_full || pop) && (in_count < FRAME_LAST);
  assign drop     = push_req && !push;

  assign cpu_run    = (state == RUN) && (fifo_count < RUN_LIMIT) && (in_count < FRAME_LAST);
  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);
  assign byte_count = byte_count_r;
  assign overflow   = overflow_r;

  // FIFO storage: written only on an accepted byte, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= GPIO;
    end
  end

  // Sequencer, FIFO pointers and frame counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      in_count     <= '0;
      byte_count_r <= '0;
      overflow_r   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        in_count <= in_count + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (byte_count_r < FRAME_LAST) begin
          byte_count_r <= byte_count_r + 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop) begin
        overflow_r <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            // A new frame starts from a clean FIFO and cleared counters.
            state        <= RUN;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            in_count     <= '0;
            byte_count_r <= '0;
            overflow_r   <= 1'b0;
          end
        end
        RUN: begin
          if (push && (in_count == FRAME_LAST - 1'b1)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty && (byte_count_r == FRAME_LAST)) begin
            state <= DONE;
          end
        end
        DONE: begin
          // Wait for the start switch to be released; no auto-restart.
          if (!start) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gpio_stream_ctrl.md
Name: gpio_stream_ctrl

Overview:
- Sequences the processor's 8-bit GPIO output stream (one byte per GPIOEn pulse, one full 390x390 frame = 152100 bytes).
- Launches the processor run on a start request and buffers output bytes in a small FIFO.
- Throttles the processor when the FIFO nears full, and hands bytes to an external consumer over valid/ready.
- Counts delivered bytes and flags frame completion. Sits between processor GPIO/GPIOEn and the board-level output sink.

Parameters:
- DEPTH, 16, FIFO entries (power of 2, >=4).
- FRAME_BYTES, 152100, bytes per frame; frame ends after this many accepted bytes.
- CNT_W, 18, width of byte counters (2^CNT_W > FRAME_BYTES).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  run request (board switch), level.
- GPIOEn  in  1  processor byte-write strobe.
- GPIO  in  8  processor byte.
- cpu_run  out  1  processor run enable; 0 = stall.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  out_data holds a valid byte.
- out_ready  in  1  consumer accepts the byte this cycle.
- byte_count  out  CNT_W  bytes delivered (valid&&ready) this frame.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  frame fully delivered.
- overflow  out  1  sticky: a byte was dropped.

Behaviour:
- Reset (rst=0, async): state IDLE, FIFO empty, in_count=0, byte_count=0. Outputs: cpu_run=0, out_valid=0, out_data=0, busy=0, done=0, overflow=0.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 sampled -> RUN. Entering RUN clears FIFO, in_count, byte_count, overflow.
  - RUN: cpu_run = (fifo_count < DEPTH-2) && (in_count < FRAME_BYTES). Combinational from registers; 2-entry slack absorbs in-flight writes.
  - RUN -> DRAIN on the cycle the accepted write makes in_count == FRAME_BYTES.
  - DRAIN: cpu_run=0; GPIOEn ignored, no overflow. -> DONE when FIFO empty and byte_count == FRAME_BYTES.
  - DONE: done=1, cpu_run=0. start=0 sampled -> IDLE (done drops). start held 1 stays in DONE; no auto-restart.
  - GPIOEn outside RUN: ignored, no count, no overflow.
- Write: in RUN with GPIOEn=1, GPIO is accepted if FIFO not full, or full with a pop in the same cycle. Otherwise dropped and overflow set (sticky until next RUN entry). Each accepted byte increments in_count.
- Read: out_valid = FIFO non-empty; out_data = head (first-word fall-through, 0 when empty). A pop occurs on out_valid && out_ready and increments byte_count. out_data/out_valid hold stable while out_valid && !out_ready.
- Latency: a byte accepted at edge N is visible on out_data/out_valid after edge N; earliest pop at edge N+1.
- Simultaneous push and pop:
  - Empty FIFO: no pop possible; the push proceeds.
  - Otherwise both proceed; fifo_count unchanged.
- Pointers wrap modulo DEPTH. fifo_count range 0..DEPTH, with distinct full and empty.
- Counters saturate at FRAME_BYTES; no wrap.
- Reset mid-frame: immediate return to reset values. Buffered bytes are discarded.
- start deasserted during RUN/DRAIN: no effect; the frame completes.

Test Plan (bench overrides DEPTH=4, FRAME_BYTES=8, CNT_W=4):
- Reset then idle: rst=0 pulse, start=0, GPIOEn toggling -> all outputs 0; FIFO stays empty; no overflow.
- Normal frame: start=1, GPIOEn=1 every cycle with bytes 0x10..0x17, out_ready=1 -> out_data 0x10..0x17 in order, each one edge after its write; byte_count 8; DRAIN then done=1; cpu_run=0 after 8th accept.
- Backpressure: out_ready=0, GPIOEn=1 -> cpu_run falls when fifo_count reaches 2. Writes accepted until full (4). A 5th write sets overflow=1 and the byte is lost. out_ready=1 drains 4 bytes in order.
- Simultaneous push/pop at full: fifo_count=4, GPIOEn=1 and out_ready=1 same cycle -> write accepted, count stays 4, overflow stays 0.
- Done/restart handshake: after done=1 with start held 1 -> stays DONE. start=0 -> IDLE, done=0. start=1 -> new frame with counters cleared.
- Async reset mid-frame: rst=0 after 3 bytes, asserted between clock edges -> outputs clear immediately. After release and start=1, a fresh 8-byte frame completes normally.
